// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: sll/srl/sra/ror, one bit per clock.
// Start/busy/done handshake; result register holds until the next DONE.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    logic [WIDTH-1:0] dout_n;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = acc;
        unique case (op_q)
            OP_SLL: shifted = {acc[WIDTH-2:0], 1'b0};
            OP_SRL: shifted = {1'b0, acc[WIDTH-1:1]};
            OP_SRA: shifted = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_ROR: shifted = {acc[0], acc[WIDTH-1:1]};
            default: shifted = acc;
        endcase
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_q;
        dout_n  = data_out;
        unique case (state)
            IDLE: begin
                if (start) begin
                    op_n  = op;
                    acc_n = data_in;
                    cnt_n = shamt;
                    if (shamt == '0) begin
                        dout_n  = data_in;
                        state_n = DONE;
                    end else begin
                        state_n = SHIFT;
                    end
                end
            end
            SHIFT: begin
                acc_n = shifted;
                cnt_n = cnt - 1'b1;
                // last step: publish the shifted value, never intermediates
                if (cnt == SHW'(1)) begin
                    dout_n  = shifted;
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            op_q     <= OP_SLL;
            data_out <= '0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            cnt      <= cnt_n;
            op_q     <= op_n;
            data_out <= dout_n;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboarded bench for shift_sequencer: directed vectors plus random
// requests against an arithmetic shift model.
module tb_shift_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [3:0]   shamt = 4'd0;
    logic [W-1:0] data_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;

    shift_sequencer #(.WIDTH(W), .SHW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .shamt    (shamt),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
        int           blen;
    } exp_t;

    exp_t         sb[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           ncyc     = 0;
    int           bcnt     = 0;
    logic [W-1:0] last_res = '0;

    function automatic logic [W-1:0] model(input logic [1:0] o,
                                           input int s,
                                           input logic [W-1:0] d);
        logic signed [W-1:0] sd;
        logic [2*W-1:0]      t;
        sd = d;
        t  = {d, d} >> s;
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return sd >>> s;
            default: return t[W-1:0];
        endcase
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
        end
    endtask

    // monitor: counts negedges, tracks busy length, pops on done
    always @(negedge clk) begin
        exp_t e;
        ncyc++;
        if (busy === 1'b1) bcnt++;
        else bcnt = 0;
        if (rst && done === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL spurious_done: done=1 at cycle %0d with nothing pending",
                         ncyc);
            end else begin
                e = sb.pop_front();
                if (data_out !== e.data || ncyc != e.cyc || bcnt != e.blen) begin
                    n_fail++;
                    $display("FAIL result: data 0x%04h cyc %0d busy %0d expected 0x%04h cyc %0d busy %0d",
                             data_out, ncyc, bcnt, e.data, e.cyc, e.blen);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input int s,
                         input logic [W-1:0] d, input bit poke);
        exp_t e;
        bit   fin;
        @(negedge clk);
        #1;
        start   = 1'b1;
        op      = o;
        shamt   = 4'(s);
        data_in = d;
        e.data  = model(o, s, d);
        e.cyc   = ncyc + s + 1;
        e.blen  = s + 1;
        sb.push_back(e);
        fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            @(negedge clk);
            #1;
            if (poke) begin
                start   = busy;
                op      = 2'b00;
                shamt   = 4'd1;
                data_in = 16'hFFFF;
            end else begin
                start = 1'b0;
            end
            if (sb.size() == 0) fin = 1'b1;
            else if (busy && !done) chk("hold", data_out, last_res);
        end
        start = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no done for op %0d shamt %0d", o, s);
            sb.delete();
        end
        last_res = e.data;
        @(negedge clk);
        #1;
        chk("idle_busy", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        #20;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_dout", data_out, 16'h0000);
        #30;
        rst = 1'b1;
        #10;
        chk("post_rst_dout", data_out, 16'h0000);

        issue(2'b00, 4,  16'h0001, 1'b0);
        chk("sll4", data_out, 16'h0010);
        issue(2'b10, 15, 16'h8000, 1'b0);
        chk("sra15", data_out, 16'hFFFF);
        issue(2'b01, 15, 16'hFFFF, 1'b0);
        chk("srl15", data_out, 16'h0001);
        issue(2'b01, 0,  16'h002E, 1'b0);
        chk("zero", data_out, 16'h002E);
        issue(2'b11, 4,  16'h001A, 1'b0);
        chk("ror4", data_out, 16'hA001);
        issue(2'b11, 1,  16'h0030, 1'b0);
        chk("ror1", data_out, 16'h0018);
        issue(2'b00, 8,  16'h0034, 1'b1);
        chk("busy_reject", data_out, 16'h3400);
        repeat (3) @(negedge clk);

        // abort mid-operation with an asynchronous reset
        @(negedge clk);
        #1;
        start   = 1'b1;
        op      = 2'b01;
        shamt   = 4'd10;
        data_in = 16'hFFFF;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_done", {15'd0, done}, 16'd0);
        chk("abort_dout", data_out, 16'h0000);
        repeat (2) @(negedge clk);
        #1;
        rst      = 1'b1;
        last_res = '0;
        issue(2'b00, 1, 16'h0001, 1'b0);
        chk("after_abort", data_out, 16'h0002);

        for (int k = 0; k < 30; k++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  16'($urandom), 1'b0);
        end
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
